// File: rtl/led_pwm.sv
// PWM brightness stage for the four board LEDs: per-LED 8-bit duty, double-buffered
// so a new duty word only takes effect at a PWM period boundary.
module led_pwm #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic        sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [3:0]  led_on,
  output logic [3:0]  LED
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [31:0] pending_q, pending_d;
  logic [31:0] active_q,  active_d;
  logic [15:0] presc_q,   presc_d;
  logic [7:0]  phase_q,   phase_d;
  logic [3:0]  led_q,     led_d;
  logic        tick;
  logic        wrap;
  logic [7:0]  duty;

  // Reads have no side effects, so the read strobe carries no information here.
  logic unused_rstrb;
  assign unused_rstrb = rstrb;

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    wrap      = tick && (phase_q == 8'hFF);
    presc_d   = tick ? '0 : presc_q + 16'd1;
    phase_d   = tick ? phase_q + 8'd1 : phase_q;
    pending_d = (sel && wstrb) ? wdata : pending_q;
    // Active samples the pre-write pending value, so a write landing on the
    // wrap edge waits a full period.
    active_d  = wrap ? pending_q : active_q;
    led_d     = '0;
    duty      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      duty     = active_q[8*i +: 8];
      led_d[i] = led_on[i] & ((duty == 8'hFF) || (phase_q < duty));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '1;
      active_q  <= '1;
      presc_q   <= '0;
      phase_q   <= '0;
      led_q     <= '0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      led_q     <= led_d;
    end
  end

  assign rdata = sel ? pending_q : '0;
  assign LED   = led_q;

endmodule

// File: tb/tb_led_pwm.sv
// Scoreboard bench for led_pwm: the stimulus process predicts LED/rdata from an
// arithmetic model of the PWM timeline; a monitor compares every cycle.
module tb_led_pwm;

  localparam int unsigned P      = 2;
  localparam int unsigned PERIOD = 256 * P;

  logic        clk;
  logic        reset;
  logic        rstrb;
  logic        wstrb;
  logic        sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  led_on;
  logic [3:0]  LED;

  led_pwm #(.PRESCALE(P)) dut (
    .clk    (clk),
    .reset  (reset),
    .rstrb  (rstrb),
    .wstrb  (wstrb),
    .sel    (sel),
    .wdata  (wdata),
    .rdata  (rdata),
    .led_on (led_on),
    .LED    (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  led;
    logic [31:0] rdata;
    int unsigned k;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;

  // Model state: k = clock edges since reset released (phase = (k/P)%256).
  logic [31:0] m_pending;
  logic [31:0] m_active;
  int unsigned k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic s, input logic w,
                       input logic [31:0] wd, input logic [3:0] lo);
    exp_t        e;
    logic [7:0]  d;
    int unsigned ph;
    logic [31:0] nxt;
    @(negedge clk);
    reset  = rst;
    sel    = s;
    wstrb  = w;
    wdata  = wd;
    led_on = lo;
    rstrb  = 1'($urandom_range(0, 1));
    e.led  = '0;
    if (rst) begin
      m_pending = '1;
      m_active  = '1;
      k         = 0;
    end else begin
      ph = (k / P) % 256;
      for (int i = 0; i < 4; i++) begin
        d        = m_active[8*i +: 8];
        e.led[i] = lo[i] && ((d == 8'hFF) || (ph < int'(d)));
      end
      nxt = (((k + 1) % PERIOD) == 0) ? m_pending : m_active;
      if (s && w) m_pending = wd;
      m_active = nxt;
      k++;
    end
    e.rdata = s ? m_pending : 32'h0;
    e.k     = k;
    sb.push_back(e);
  endtask

  task automatic idle(input logic s, input logic [3:0] lo);
    cycle(1'b0, s, 1'b0, 32'h0, lo);
  endtask

  task automatic wr(input logic [31:0] wd, input logic [3:0] lo);
    cycle(1'b0, 1'b1, 1'b1, wd, lo);
  endtask

  task automatic idle_until_period_start(input logic [3:0] lo);
    idle(1'b1, lo);
    while ((k % PERIOD) != 0) idle(1'($urandom_range(0, 1)), lo);
  endtask

  task automatic idle_until_phase(input int unsigned ph, input logic [3:0] lo);
    while (((k / P) % 256) != ph || (k % P) != 0) idle(1'($urandom_range(0, 1)), lo);
  endtask

  function automatic logic [31:0] rand_duty();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       v[8*i +: 8] = 8'h00;
        1:       v[8*i +: 8] = 8'hFF;
        default: v[8*i +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return v;
  endfunction

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), rand_duty(), 4'($urandom_range(0, 15)));
    end
  endtask

  // Monitor: LED and rdata are presented every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("led k=%0d", e.k), {28'h0, LED}, {28'h0, e.led});
        check($sformatf("rdata k=%0d", e.k), rdata, e.rdata);
      end
    end
  end

  initial begin
    int l0_cnt, l2_cnt, l13_cnt, l0_edges;
    logic prev0;
    reset  = 1'b1;
    rstrb  = 1'b0;
    wstrb  = 1'b0;
    sel    = 1'b0;
    wdata  = '0;
    led_on = 4'hF;
    m_pending = '1;
    m_active  = '1;
    k         = 0;

    // Reset and read-back
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'hF);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) idle(1'(i % 2), 4'hF);

    rand_cycles(600);

    // Duty ratios over one full period
    while ((k % PERIOD) == PERIOD - 1) idle(1'b1, 4'hF);
    wr(32'h0040_0080, 4'hF);
    idle_until_period_start(4'hF);
    l0_cnt = 0; l2_cnt = 0; l13_cnt = 0; l0_edges = 0; prev0 = 1'b0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      idle(1'b1, 4'hF);
      @(posedge clk);
      #2;
      if (i == 0) check("led0 high at phase 0", {31'h0, LED[0]}, 32'h1);
      if (LED[0] && !prev0) l0_edges++;
      prev0 = LED[0];
      l0_cnt  += int'(LED[0]);
      l2_cnt  += int'(LED[2]);
      l13_cnt += int'(LED[1]) + int'(LED[3]);
    end
    check("led0 high cycles", l0_cnt, 256);
    check("led0 single run", l0_edges, 1);
    check("led2 high cycles", l2_cnt, 128);
    check("led1/3 high cycles", l13_cnt, 0);

    // Double buffering: write 0 mid-period, full-on holds until the wrap
    wr(32'hFFFF_FFFF, 4'hF);
    idle_until_period_start(4'hF);
    idle_until_phase(100, 4'hF);
    wr(32'h0, 4'hF);
    idle_until_period_start(4'hF);
    for (int i = 0; i < 4; i++) idle(1'b1, 4'hF);

    // Write exactly on the wrap edge
    wr(32'h80FF_4001, 4'hF);
    idle_until_period_start(4'hF);
    idle_until_phase(50, 4'hF);
    wr(32'h20C0_00FF, 4'hF);
    while ((k % PERIOD) != PERIOD - 1) idle(1'b1, 4'hF);
    wr(32'h0000_FF10, 4'hF);
    for (int i = 0; i < int'(PERIOD) + 8; i++) idle(1'b1, 4'hF);

    // led_on gating at full duty
    wr(32'hFFFF_FFFF, 4'hF);
    idle_until_period_start(4'hF);
    for (int i = 0; i < 10; i++) idle(1'b1, 4'hF);
    for (int i = 0; i < 10; i++) idle(1'b1, 4'h5);
    for (int i = 0; i < 5; i++) idle(1'b0, 4'hA);

    // Reset mid-operation with a concurrent write
    wr(32'h0F0F_0F0F, 4'hF);
    idle_until_period_start(4'hF);
    idle_until_phase(37, 4'hF);
    cycle(1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 20; i++) idle(1'b1, 4'hF);

    rand_cycles(1500);

    for (int i = 0; i < 3 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pwm.md
# led_pwm

Memory-mapped PWM brightness stage placed directly downstream of the LED on/off register in the quark SoC IO space. It takes the 4-bit on/off vector that the LED register produces and drives the board LED pins with it. Each LED gets a per-LED 8-bit duty value, and duty updates are double-buffered so they only take effect at a PWM period boundary (glitch-free). Its bus port uses the same simple select/strobe protocol as the other IO peripherals.

## Interface
- PRESCALE, default 16: clocks per PWM phase tick; legal range 1..65535.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rstrb  in  1  read strobe; accepted but unused, because reads are side-effect free.
- wstrb  in  1  write strobe.
- sel  in  1  peripheral select; reads and writes are ignored when low.
- wdata  in  32  write data: byte i (bits 8i+7:8i) is the duty for LED i.
- rdata  out  32  read data: the pending duty word when sel=1, else 32'h0.
- led_on  in  4  per-LED enable from the upstream LED register.
- LED  out  4  LED pins.

## Operation
- Registers:
  - pending[31:0]: bus-visible duty word.
  - active[31:0]: duty word in use.
  - presc: counter 0..PRESCALE-1.
  - phase[7:0]: PWM phase.
  - led_q[3:0]: drives LED.
- Reset values: pending = active = 32'hFFFFFFFF (full brightness, so the block behaves as a plain on/off driver); presc = 0; phase = 0; LED = 4'h0.
- Write: on sel && wstrb, pending <= wdata. There are no byte enables; all 32 bits are written.
- Read: rdata = sel ? pending : 32'h0. The read path is combinational with no side effects.
- Prescaler:
  - tick = (presc == PRESCALE-1).
  - On tick, presc <= 0; otherwise presc <= presc+1.
  - PRESCALE=1 gives tick every cycle.
- Phase: on tick, phase <= phase+1, wrapping modulo 256 (255 -> 0).
- Period boundary: wrap = tick && phase == 255. On wrap, active <= pending.
- Compare, per LED i with d = active[8i+7:8i]:
  - on_i = (d == 8'hFF) ? 1 : (phase < d).
  - d = 0 gives always off.
  - d = 255 gives always on, with no one-tick gap.
  - Otherwise the LED is high for d of 256 phases.
- Output: every cycle, led_q[i] <= led_on[i] & on_i.
- Simultaneous write and wrap on the same edge: active takes the old pending value, and pending takes wdata. The new value is applied at the next wrap, one full period later.
- Reset asserted mid-period, with or without a concurrent write: reset wins. All registers take their reset values and the write is dropped.

## Timing
- PWM period = 256 × PRESCALE clocks. Phase 0 starts on the first cycle after reset deasserts.
- Write latency:
  - Visible on rdata the cycle after the write edge.
  - Reaches active at the first wrap edge after the write edge.
  - Reaches LED one cycle after that.
- LED is registered with exactly one cycle of latency from phase, active and led_on. A led_on change at edge N is visible on LED after edge N+1.
- LED is 4'h0 during reset and for the first cycle after reset deasserts.
- No handshake or backpressure: every sel && wstrb write completes in one cycle.

## Test plan
- Reset/read (PRESCALE=2):
  - Hold reset for 3 cycles with led_on=4'hF, then release.
  - LED = 4'h0 for one cycle, then 4'hF continuously.
  - rdata = 32'hFFFFFFFF with sel=1 and 32'h0 with sel=0.
- Duty ratios (PRESCALE=2):
  - Write 32'h00_40_00_80 (LED3=0x00, LED2=0x40, LED1=0x00, LED0=0x80) with led_on=4'hF, then wait for a wrap.
  - Over the next 512-cycle period, LED0 is high exactly 256 contiguous cycles starting at phase 0, and LED2 is high exactly 128 cycles.
  - LED1 and LED3 are never high.
- Double buffering:
  - Write 32'h0 at phase 100.
  - LED keeps the full-on value until the wrap edge, then goes 4'h0 one cycle after it.
  - rdata = 32'h0 immediately after the write.
- Write on wrap edge:
  - Assert the write exactly on the wrap cycle.
  - active retains the prior pending value for the whole next period.
  - The new duty appears only after the following wrap, 256 × PRESCALE cycles later.
- led_on gating:
  - Set duty 32'hFFFFFFFF and toggle led_on 4'hF -> 4'h5 at edge N.
  - LED = 4'h5 after edge N+1, independent of phase.
- Reset mid-operation:
  - At phase 37, assert reset together with sel && wstrb and wdata = 32'h12345678.
  - Afterwards rdata = 32'hFFFFFFFF, phase restarts at 0, and LED = 4'h0 for one cycle.
